mem_arbiter: RTL and testbench

Single-port memory arbiter that sits between the pipeline's instruction-fetch and data-access ports and the shared RAM. It serialises instruction reads and data reads/writes onto one RAM port and returns the `ihit`/`dhit` pulses and load data that the hazard unit and pipeline latches consume. It also implements the responder side of the LL/SC protocol: it keeps the link register and reports SC success or failure.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Pipeline-to-arbiter-to-RAM signal bundle; the arbiter takes the slave view,
// and the pipeline plus RAM model together take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              ihit;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic              datomic;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dhit;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises I-fetch and D-access onto one RAM port; LL/SC link built only with MEM_ARBITER_LLSC_EN.
// Hit two cycles after the request plus RAM wait cycles; requesters hold their request until the hit.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);
    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [1:0]       RAM_ERROR  = 2'd3;

    typedef enum logic [2:0] {IDLE, IREQ, DREQ, IRESP, DRESP} state_t;

    state_t            state;
    logic              last_d;
    logic              op_wr;
    logic              sc_skip;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] iload_q;
    logic [DATA_W-1:0] dload_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_nxt;
    logic              ihit_q;
    logic              dhit_q;
    logic              ren_q;
    logic              wen_q;
    logic              err_q;

    logic              d_pend;
    logic              grant_d;
    logic              sc_fail;
    logic [DATA_W-1:0] wr_resp;

    assign d_pend   = bus.dREN | bus.dWEN;
    assign grant_d  = d_pend & (~bus.iREN | ~last_d);
    assign wait_nxt = wait_cnt + CNT_W'(1);

`ifdef MEM_ARBITER_LLSC_EN
    logic              op_atomic;
    logic              link_vld;
    logic [ADDR_W-1:0] link_addr;

    // A failing SC is decided at grant time so it never touches the RAM.
    assign sc_fail = bus.datomic & bus.dWEN & ~(link_vld && (link_addr == bus.daddr));
    assign wr_resp = {{(DATA_W-1){1'b0}}, op_atomic & ~sc_skip};
`else
    logic unused_datomic;
    assign unused_datomic = bus.datomic;
    assign sc_fail        = 1'b0;
    assign wr_resp        = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            op_wr    <= 1'b0;
            sc_skip  <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
            wait_cnt <= '0;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef MEM_ARBITER_LLSC_EN
            op_atomic <= 1'b0;
            link_vld  <= 1'b0;
            link_addr <= '0;
`endif
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_d) begin
                        state   <= DREQ;
                        addr_q  <= bus.daddr;
                        store_q <= bus.dstore;
                        op_wr   <= bus.dWEN;
                        sc_skip <= sc_fail;
                        ren_q   <= ~bus.dWEN;
                        wen_q   <= bus.dWEN & ~sc_fail;
`ifdef MEM_ARBITER_LLSC_EN
                        op_atomic <= bus.datomic;
`endif
                    end else if (bus.iREN) begin
                        state   <= IREQ;
                        addr_q  <= bus.iaddr;
                        op_wr   <= 1'b0;
                        sc_skip <= 1'b0;
                        ren_q   <= 1'b1;
                        wen_q   <= 1'b0;
                    end
                end
                IREQ, DREQ: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt == CNT_MAX) err_q <= 1'b1;
                    end
                    if (sc_skip || (bus.ramstate == RAM_ACCESS)) begin
                        ren_q <= 1'b0;
                        wen_q <= 1'b0;
                        if (state == IREQ) begin
                            state   <= IRESP;
                            ihit_q  <= 1'b1;
                            iload_q <= bus.ramload;
                        end else begin
                            state   <= DRESP;
                            dhit_q  <= 1'b1;
                            dload_q <= op_wr ? wr_resp : bus.ramload;
`ifdef MEM_ARBITER_LLSC_EN
                            if (op_atomic && !op_wr) begin
                                link_vld  <= 1'b1;
                                link_addr <= addr_q;
                            end else if (op_atomic || (op_wr && (addr_q == link_addr))) begin
                                link_vld <= 1'b0;
                            end
`endif
                        end
                    end else if (bus.ramstate == RAM_ERROR) begin
                        err_q <= 1'b1;
                    end
                end
                IRESP: begin
                    last_d <= 1'b0;
                    state  <= IDLE;
                end
                DRESP: begin
                    last_d <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ihit     = ihit_q;
    assign bus.iload    = iload_q;
    assign bus.dhit     = dhit_q;
    assign bus.dload    = dload_q;
    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random accesses against a RAM model and a
// transaction-level reference (memory image, fairness side, link register, sticky error).
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ram     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int busy_left = 0, errinj_left = 0, wr_count = 0, exp_wr = 0;
    logic last_d_m = 1'b0, link_v = 1'b0, err_m = 1'b0;
    logic [31:0] link_a = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2400_000A;
    endfunction
    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    // RAM model: ERROR cycles first, then BUSY cycles, then ACCESS.
    always @(negedge clk) begin
        if (rst || !(bus.ramREN || bus.ramWEN)) begin
            bus.ramstate = 2'd0;
        end else if (errinj_left > 0) begin
            bus.ramstate = 2'd3;
            errinj_left--;
        end else if (busy_left > 0) begin
            bus.ramstate = 2'd1;
            busy_left--;
        end else begin
            bus.ramstate = 2'd2;
            if (bus.ramWEN) begin
                ram[bus.ramaddr] = bus.ramstore;
                wr_count++;
            end else begin
                bus.ramload = ram_rd(bus.ramaddr);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_ihit"}, bus.ihit, 0);
        check({tag, "_dhit"}, bus.dhit, 0);
        check({tag, "_iload"}, bus.iload, 0);
        check({tag, "_dload"}, bus.dload, 0);
        check({tag, "_ramREN"}, bus.ramREN, 0);
        check({tag, "_ramWEN"}, bus.ramWEN, 0);
        check({tag, "_ramaddr"}, bus.ramaddr, 0);
        check({tag, "_ramstore"}, bus.ramstore, 0);
        check({tag, "_err"}, bus.err, 0);
    endtask

    // kind: 0 = instruction read, 1 = data read (LL if atomic), 2 = data write (SC if atomic)
    task automatic run_access(input int kind, input logic atomic, input logic [31:0] addr,
                              input logic [31:0] wdata, input int busy, input int errs);
        logic is_d, is_wr, is_sc, sc_ok, strobes, got, exp_err;
        logic [31:0] exp_load;
        int lat, k;
        is_d  = (kind != 0);
        is_wr = (kind == 2);
        is_sc = 1'b0;
        sc_ok = 1'b0;
`ifdef MEM_ARBITER_LLSC_EN
        is_sc = is_wr && atomic;
        sc_ok = link_v && (link_a == addr);
`endif
        strobes     = !(is_sc && !sc_ok);
        lat         = strobes ? 2 + busy + errs : 2;
        busy_left   = busy;
        errinj_left = errs;
        exp_load    = !is_wr ? ref_rd(addr) : ((is_sc && sc_ok) ? 32'd1 : 32'd0);

        bus.iREN    = !is_d;
        bus.dREN    = (kind == 1);
        bus.dWEN    = is_wr;
        bus.datomic = atomic;
        bus.iaddr   = is_d ? 32'h0 : addr;
        bus.daddr   = is_d ? addr : 32'h0;
        bus.dstore  = wdata;
        got = 1'b0;
        k   = 0;
        while (!got && k < 64) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.iaddr  = $urandom;
                bus.daddr  = $urandom;
                bus.dstore = $urandom;
            end
            got = is_d ? bus.dhit : bus.ihit;
            exp_err = err_m | (strobes && errs > 0 && k >= 2) | (strobes && (k - 1) >= TMO);
            check("err_track", bus.err, exp_err);
            if (!got) begin
                check("ramREN", bus.ramREN, strobes && !is_wr);
                check("ramWEN", bus.ramWEN, strobes && is_wr);
                if (strobes) check("ramaddr", bus.ramaddr, addr);
                if (strobes && is_wr) check("ramstore", bus.ramstore, wdata);
            end
        end
        check("latency", k, lat);
        check("other_hit", is_d ? bus.ihit : bus.dhit, 0);
        check(is_d ? "dload" : "iload", is_d ? bus.dload : bus.iload, exp_load);

        bus.iREN    = 1'b0;
        bus.dREN    = 1'b0;
        bus.dWEN    = 1'b0;
        bus.datomic = 1'b0;
        if (is_wr && strobes) begin
            ref_mem[addr] = wdata;
            exp_wr++;
        end
`ifdef MEM_ARBITER_LLSC_EN
        if (kind == 1 && atomic) begin
            link_v = 1'b1;
            link_a = addr;
        end else if (is_sc || (is_wr && link_a == addr)) begin
            link_v = 1'b0;
        end
`endif
        last_d_m = is_d;
        if (strobes && (errs > 0 || (lat - 1) >= TMO)) err_m = 1'b1;
        check("ram_writes", wr_count, exp_wr);
        check("ram_image", ram_rd(addr), ref_rd(addr));
        @(posedge clk);
        @(negedge clk);
        check("idle_hits", {bus.ihit, bus.dhit}, 0);
    endtask

    // Both sides request continuously; grants must alternate starting opposite to last served.
    task automatic run_dual(input int n, input logic [31:0] ia, input logic [31:0] da);
        int k, idx;
        logic exp_d;
        busy_left   = 0;
        errinj_left = 0;
        bus.iREN    = 1'b1;
        bus.dREN    = 1'b1;
        bus.dWEN    = 1'b0;
        bus.datomic = 1'b0;
        bus.iaddr   = ia;
        bus.daddr   = da;
        k   = 0;
        idx = 0;
        while (idx < n && k < 3 * n + 10) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            check("hits_exclusive", bus.ihit & bus.dhit, 0);
            if (bus.ihit || bus.dhit) begin
                exp_d = !last_d_m;
                check("grant_side", bus.dhit, exp_d);
                check("grant_spacing", k, 2 + 3 * idx);
                check("dual_load", bus.dhit ? bus.dload : bus.iload, exp_d ? ref_rd(da) : ref_rd(ia));
                last_d_m = exp_d;
                idx++;
            end
        end
        check("dual_count", idx, n);
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, busy;
        logic atm;
        logic [31:0] a;

        rst          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.datomic  = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_dual(2, 32'h0000_0040, 32'h0000_0080);
        run_access(0, 1'b0, 32'h0, 32'h0, 0, 0);
        check("first_fetch_word", bus.iload, 32'h2400_000A);
        run_access(2, 1'b0, 32'h100, 32'hDEAD_BEEF, 3, 0);
        run_access(1, 1'b0, 32'h100, 32'h0, 0, 0);
        run_dual(6, 32'h0000_0044, 32'h0000_0100);

        run_access(1, 1'b1, 32'h200, 32'h0, 0, 0);
        run_access(2, 1'b1, 32'h200, 32'h1111_2222, 1, 0);
        run_access(1, 1'b1, 32'h200, 32'h0, 0, 0);
        run_access(2, 1'b0, 32'h200, 32'h3333_4444, 0, 0);
        run_access(2, 1'b1, 32'h200, 32'h5555_6666, 2, 0);
        run_access(1, 1'b0, 32'h200, 32'h0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            atm  = (kind != 0) && ($urandom_range(0, 2) == 0);
            busy = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       a = 32'h200;
                1:       a = 32'h204;
                2:       a = 32'h100;
                default: a = 32'($urandom_range(0, 1023)) << 2;
            endcase
            run_access(kind, atm, a, $urandom, busy, 0);
        end

        run_access(1, 1'b0, 32'h180, 32'h0, 10, 0);
        run_access(0, 1'b0, 32'h184, 32'h0, 0, 0);

        busy_left   = 5;
        errinj_left = 0;
        bus.dREN    = 1'b1;
        bus.daddr   = 32'h300;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_mid_req", bus.ramREN, 1);
        rst      = 1'b1;
        bus.dREN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b0;
        last_d_m = 1'b0;
        link_v   = 1'b0;
        err_m    = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_no_dhit", bus.dhit, 0);
        end

        run_access(1, 1'b0, 32'h104, 32'h0, 1, 2);
        run_access(0, 1'b0, 32'h108, 32'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
